// File: rtl/ter_pkg.sv
// Shared types and ternary arithmetic for the cyclic Z3 convolution sequencer.
// Coefficients are {sign, nonzero}; 2'b10 is read as zero.
package ter_pkg;

   localparam int CW = 2;

   typedef logic [CW-1:0] ter_t;

   localparam ter_t TER_ZERO = 2'b00;
   localparam ter_t TER_POS  = 2'b01;
   localparam ter_t TER_NEG  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic ter_t ter_mask(input ter_t v);
      return {v[1] & v[0], v[0]};
   endfunction

   function automatic ter_t ter_mul(input ter_t x, input ter_t y);
      ter_t xm;
      ter_t ym;
      xm = ter_mask(x);
      ym = ter_mask(y);
      if (xm[0] && ym[0]) return {xm[1] ^ ym[1], 1'b1};
      return TER_ZERO;
   endfunction

   // Equal nonzero operands wrap mod 3: 1+1 = -1, -1-1 = +1.
   function automatic ter_t ter_add(input ter_t x, input ter_t y);
      ter_t xm;
      ter_t ym;
      xm = ter_mask(x);
      ym = ter_mask(y);
      if (!xm[0]) return ym;
      if (!ym[0]) return xm;
      if (xm == ym) return (xm == TER_POS) ? TER_NEG : TER_POS;
      return TER_ZERO;
   endfunction

   function automatic ter_t ter_mac(input ter_t acc, input ter_t b, input ter_t a);
      return ter_add(acc, ter_mul(b, a));
   endfunction

endpackage

// File: rtl/ter_conv_ctrl_if.sv
// Handshake and polynomial bus of the convolution sequencer.
// acc_keep exists only when TER_CONV_ACC_EN is defined.
interface ter_conv_ctrl_if #(parameter int N = 701);
   logic           start;
   logic           abort;
   logic [2*N-1:0] a_in;
   logic [2*N-1:0] b_in;
   logic           busy;
   logic           done;
   logic [2*N-1:0] c_out;
`ifdef TER_CONV_ACC_EN
   logic           acc_keep;
`endif

   modport master (
`ifdef TER_CONV_ACC_EN
      output acc_keep,
`endif
      output start, abort, a_in, b_in,
      input  busy, done, c_out
   );

   modport slave (
`ifdef TER_CONV_ACC_EN
      input  acc_keep,
`endif
      input  start, abort, a_in, b_in,
      output busy, done, c_out
   );
endinterface

// File: rtl/ter_mac_lane.sv
// One accumulator coefficient with its ternary multiply-add.
// acc_nxt is the post-MAC value, exposed so the top can latch it into c_out.
module ter_mac_lane
   import ter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  ter_t init,
   input  logic mac_en,
   input  ter_t b,
   input  ter_t a,
   output ter_t acc_nxt
);

   ter_t acc_q;
   ter_t acc_d;

   always_comb begin
      acc_nxt = ter_mac(acc_q, b, a);
      acc_d   = acc_q;
      if (load)        acc_d = init;
      else if (mac_en) acc_d = acc_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= TER_ZERO;
      else     acc_q <= acc_d;
   end

endmodule

// File: rtl/ter_conv_ctrl.sv
// Serial-by-coefficient cyclic convolution c = a*b mod (x^N - 1) over Z3.
// Optional TER_CONV_ACC_EN: acc_keep on start seeds the accumulator with c_out.
//
// state   | meaning
// IDLE    | waiting for start; c_out holds last result
// RUN     | one MAC per cycle, rotate a, shift b
// DONE    | one-cycle done pulse, then back to IDLE
module ter_conv_ctrl
   import ter_pkg::*;
#(
   parameter int N = 701
) (
   input logic             clk,
   input logic             rst,
   ter_conv_ctrl_if.slave  bus
);

   localparam int W     = CW * N;
   localparam int CNT_W = $clog2(N);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     c_q, c_d;
   logic [W-1:0]     acc_init;
   logic [W-1:0]     acc_nxt;
   logic             acc_load;
   logic             mac_en;

`ifdef TER_CONV_ACC_EN
   assign acc_init = bus.acc_keep ? c_q : '0;
`else
   assign acc_init = '0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      acc_load = 1'b0;
      mac_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d      = bus.a_in;
               b_d      = bus.b_in;
               cnt_d    = '0;
               acc_load = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            // abort beats the final MAC: no result, no pulse
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else begin
               mac_en = 1'b1;
               a_d    = {a_q[W-CW-1:0], a_q[W-1:W-CW]};
               b_d    = {{CW{1'b0}}, b_q[W-1:CW]};
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N - 1)) begin
                  c_d     = acc_nxt;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      ter_mac_lane u_lane (
         .clk     (clk),
         .rst     (rst),
         .load    (acc_load),
         .init    (acc_init[CW*i +: CW]),
         .mac_en  (mac_en),
         .b       (b_q[CW-1:0]),
         .a       (a_q[CW*i +: CW]),
         .acc_nxt (acc_nxt[CW*i +: CW])
      );
   end

   assign bus.busy  = (state_q == ST_RUN);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.c_out = c_q;

endmodule

// File: tb/tb_ter_conv_ctrl.sv
// Self-checking bench for ter_conv_ctrl at N=5 against an integer convolution model.
// Define TER_CONV_ACC_EN to also exercise acc_keep.
module tb_ter_conv_ctrl;

   localparam int N = 5;
   localparam int W = 2 * N;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ter_conv_ctrl_if #(.N(N)) bus ();
   ter_conv_ctrl #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   logic [W-1:0] last_c;

   function automatic int dec(input logic [1:0] v);
      if (v == 2'b01) return 1;
      if (v == 2'b11) return -1;
      return 0;
   endfunction

   function automatic logic [1:0] enc(input int v);
      int m;
      m = ((v % 3) + 3) % 3;
      if (m == 1) return 2'b01;
      if (m == 2) return 2'b11;
      return 2'b00;
   endfunction

   // c = init + a*b mod (x^N - 1), coefficients mod 3
   function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] init);
      int acc [N];
      logic [W-1:0] r;
      for (int i = 0; i < N; i++) acc[i] = dec(init[2*i +: 2]);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            acc[(i + j) % N] += dec(a[2*i +: 2]) * dec(b[2*j +: 2]);
      r = '0;
      for (int i = 0; i < N; i++) r[2*i +: 2] = enc(acc[i]);
      return r;
   endfunction

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic keep);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
`ifdef TER_CONV_ACC_EN
      bus.acc_keep = keep;
`else
      if (keep) $display("note: acc_keep requested but feature not built");
`endif
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a_in  = W'($urandom);
      bus.b_in  = W'($urandom);
`ifdef TER_CONV_ACC_EN
      bus.acc_keep = 1'b0;
`endif
   endtask

   task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic keep, input logic mid_start);
      logic [W-1:0] exp;
      int busy_cnt, done_cnt, done_at, overlap, hold_bad;
      exp = model(a, b, keep ? last_c : '0);
      busy_cnt = 0; done_cnt = 0; done_at = -1; overlap = 0; hold_bad = 0;
      launch(a, b, keep);
      for (int k = 0; k <= N + 2; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         if (mid_start && k == 2) bus.start = 1'b1;
         if (mid_start && k == 3) bus.start = 1'b0;
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (bus.busy && bus.done) overlap++;
         if (k < N && bus.c_out !== last_c) hold_bad++;
      end
      total++;
      if (bus.c_out !== exp) begin
         bad++;
         $display("FAIL %s c_out got=%b exp=%b", name, bus.c_out, exp);
      end
      total++;
      if (busy_cnt != N) begin
         bad++;
         $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cnt, N);
      end
      // done seen right after E_N, i.e. sampled at E_{N+1}
      total++;
      if (done_at != N || done_cnt != 1) begin
         bad++;
         $display("FAIL %s done_timing at=%0d cnt=%0d exp at=%0d cnt=1", name, done_at, done_cnt, N);
      end
      total++;
      if (overlap != 0 || hold_bad != 0) begin
         bad++;
         $display("FAIL %s overlap=%0d hold_err=%0d exp 0/0", name, overlap, hold_bad);
      end
      last_c = exp;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.a_in  = '0;
      bus.b_in  = '0;
`ifdef TER_CONV_ACC_EN
      bus.acc_keep = 1'b0;
`endif
      #12;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.c_out !== '0) begin
         bad++;
         $display("FAIL reset busy=%b done=%b c_out=%b exp 0/0/0", bus.busy, bus.done, bus.c_out);
      end
      @(negedge clk);
      rst = 1'b0;
      last_c = '0;
   endtask

   task automatic test_abort(input string name, input int abort_edge);
      int seen_done;
      seen_done = 0;
      launch(W'($urandom), W'($urandom), 1'b0);
      repeat (abort_edge - 1) @(posedge clk);
      #1 bus.abort = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy_after_abort got=%b exp=0", name, bus.busy);
      end
      for (int k = 0; k < 4; k++) begin
         if (bus.done) seen_done++;
         @(posedge clk);
         #1;
      end
      total++;
      if (seen_done != 0 || bus.c_out !== last_c) begin
         bad++;
         $display("FAIL %s done_pulses=%0d c_out=%b exp 0 and %b", name, seen_done, bus.c_out, last_c);
      end
   endtask

   task automatic test_rst_mid();
      launch(W'($urandom), W'($urandom), 1'b0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.c_out !== '0) begin
         bad++;
         $display("FAIL rst_mid busy=%b done=%b c_out=%b exp 0/0/0", bus.busy, bus.done, bus.c_out);
      end
      last_c = '0;
      @(negedge clk);
      rst = 1'b0;
      run_check("start_ignored_busy", W'($urandom), W'($urandom), 1'b0, 1'b1);
   endtask

   task automatic test_random(input int count);
      for (int t = 0; t < count; t++)
         run_check("random", W'($urandom), W'($urandom), 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      run_check("identity", 10'b11_01_00_11_01, 10'b11_01_00_11_01 & 10'b00_00_00_00_11
                | 10'b00_00_00_00_00, 1'b0, 1'b0);
      run_check("identity_b", 10'b00_00_00_00_01, 10'b11_01_00_11_01, 1'b0, 1'b0);
`ifdef TER_CONV_ACC_EN
      run_check("acc_keep", 10'b00_00_00_00_01, 10'b11_01_00_11_01, 1'b1, 1'b0);
      run_check("acc_keep_rand", W'($urandom), W'($urandom), 1'b1, 1'b0);
`endif
      run_check("wrap", 10'b00_00_00_01_00, 10'b01_00_00_00_00, 1'b0, 1'b0);
      run_check("carry", 10'b00_00_00_01_01, 10'b00_00_00_01_01, 1'b0, 1'b0);
      test_abort("abort_run3", 3);
      run_check("after_abort", W'($urandom), W'($urandom), 1'b0, 1'b0);
      test_abort("abort_final", N);
      run_check("masked_10", 10'b10_01_10_11_01, 10'b01_10_11_10_01, 1'b0, 1'b0);
      test_random(6);
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
